decoder_stream: RTL and testbench
=================================

# decoder_stream

Parametrised, registered successor to the team's combinational binary-to-one-hot decoder. It accepts decode commands over a valid/ready handshake and returns registered output beats in one of three modes: one-hot, thermometer, or multi-beat one-hot scan. It sits between a command source, such as a register bank or sequencer, and select/strobe fan-out logic. The output register lets it tolerate back-pressure from that fan-out logic.

## Interface
- IN_BITS, 4, width of the binary code
- NUM_BITS, 16, output width; legal range 2..2**IN_BITS
- CNT_BITS, 4, width of the scan beat-count field
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  command accepted when in_valid && in_ready
- binary_in  input  IN_BITS  code, or scan start code
- mode  input  2  00 one-hot, 01 thermometer, 10 scan, 11 reserved
- count  input  CNT_BITS  scan mode: number of beats minus 1; ignored in other modes
- enable  input  1  sampled with the command; 0 forces an all-zero result
- out_valid  output  1  output beat present
- out_ready  input  1  beat consumed when out_valid && out_ready
- decoder_out  output  NUM_BITS  decoded beat
- out_err  output  1  beat carries an error (code out of range, or mode 11)
- out_last  output  1  final beat of the command
- busy  output  1  a scan is in progress

## Operation
- **States**
  - IDLE: ready for commands.
  - SCAN: emitting scan beats.
- **in_ready**
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - in_ready is deasserted for the whole scan.
- **On accept in IDLE, the output register loads:**
  - enable = 0: decoder_out = 0, out_err = 0, out_last = 1, in any mode.
  - Range check: code is out of range when binary_in >= NUM_BITS (unsigned).
  - Out-of-range code in any mode: decoder_out = 0, out_err = 1, out_last = 1. No scan starts.
  - mode 00: decoder_out = 1 << binary_in, out_last = 1.
  - mode 01: bits [binary_in:0] set, all others clear. Code 0 gives 0x0001; code NUM_BITS-1 gives all ones. out_last = 1.
  - mode 10 with count = 0: a single one-hot beat, out_last = 1. State stays IDLE.
  - mode 10 with count > 0: first beat = 1 << binary_in, out_last = 0. Load ptr = binary_in + 1 (wrapped) and remaining = count. Enter SCAN.
  - mode 11: decoder_out = 0, out_err = 1, out_last = 1.
- **SCAN**
  - Each time the current beat is consumed (out_valid && out_ready), load decoder_out = 1 << ptr.
  - Then advance ptr and decrement remaining.
  - out_last = 1 on the beat loaded when remaining reaches 0. Return to IDLE as that beat is loaded.
- **Pointer arithmetic**
  - ptr wraps from NUM_BITS-1 to 0. This holds for non-power-of-two NUM_BITS (modulo NUM_BITS, not modulo 2**IN_BITS).
  - Total scan beats = count + 1, up to 2**CNT_BITS. A scan may wrap more than once.
- **Output register**
  - The beat holds stable while out_valid && !out_ready.
  - out_valid clears on consume unless a new beat loads in the same cycle.
- **busy** = (state == SCAN).
- **Reset (asynchronous, any time, including mid-scan)**
  - State goes to IDLE.
  - out_valid = 0, decoder_out = 0, out_err = 0, out_last = 0, busy = 0.
  - ptr and remaining are cleared.
  - in_ready reads 1 after reset releases.
  - Any in-flight command or scan is discarded.

## Timing
- Latency: command accepted in cycle N → beat visible, out_valid = 1, in cycle N+1.
- Throughput, single-beat modes with out_ready held high: one command per cycle.
  - Accept and consume happen in the same cycle, giving back-to-back beats.
- Scan with out_ready held high: count + 1 beats on consecutive cycles.
  - in_ready rises in the cycle the last beat is loaded, i.e. while out_last is visible. This relies on the IDLE condition using out_ready.
- Back-pressure: when out_ready = 0, no state advances and the output holds.
- All outputs are registered except in_ready, which is combinational from state, out_valid and out_ready.

## Test plan
- Reset, then mode 00, code 0x5, enable = 1, out_ready = 1 → next cycle decoder_out = 0x0020, out_last = 1, out_err = 0. Repeat for all 16 codes back-to-back → one beat per cycle.
- Mode 01, code 0x3 → 0x000F. Code 0xF → 0xFFFF. Any mode with enable = 0 → 0x0000, out_err = 0.
- NUM_BITS = 10, mode 10, start 8, count 4 → beats 0x100, 0x200, 0x001, 0x002, 0x004. out_last only on 0x004. busy high for 4 cycles. in_ready low during the scan.
- NUM_BITS = 10, code 12, mode 00 → 0x000, out_err = 1, out_last = 1. Mode 11 with code 2 → 0x000, out_err = 1.
- Scan start 0, count 3, out_ready toggled 1,0,0,1,… → each beat held stable while out_ready = 0. Exactly 4 beats 0x1, 0x2, 0x4, 0x8. No beat lost or duplicated.
- Assert reset on the 2nd beat of a count = 7 scan → out_valid = 0, busy = 0, decoder_out = 0 immediately. After release, a mode 00 code 1 command → 0x0002 with no leftover scan beats.

Source files
------------

// File: rtl/decoder_stream.sv
// decoder_stream: registered binary-to-one-hot / thermometer / scan decoder
// with valid/ready handshakes on both the command and the output side.
// A single output register holds each beat until the fan-out logic takes it.

module decoder_stream #(
    parameter int IN_BITS  = 4,
    parameter int NUM_BITS = 16,
    parameter int CNT_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  binary_in,
    input  logic [1:0]          mode,
    input  logic [CNT_BITS-1:0] count,
    input  logic                enable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] decoder_out,
    output logic                out_err,
    output logic                out_last,
    output logic                busy
);

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERMO = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // One extra bit so NUM_BITS == 2**IN_BITS is representable in the range check.
    localparam logic [IN_BITS:0]   CODE_LIMIT = (IN_BITS + 1)'(NUM_BITS);
    localparam logic [IN_BITS-1:0] PTR_MAX    = IN_BITS'(NUM_BITS - 1);

    state_e                state_q, state_d;
    logic [IN_BITS-1:0]    ptr_q, ptr_d;
    logic [CNT_BITS-1:0]   remaining_q, remaining_d;
    logic                  out_valid_q, out_valid_d;
    logic [NUM_BITS-1:0]   data_q, data_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;

    mode_e                 mode_cmd;
    logic                  code_in_range;
    logic                  consume;
    logic                  accept;

    // Bit i set only where i equals the code.
    function automatic logic [NUM_BITS-1:0] onehot(input logic [IN_BITS-1:0] idx);
        logic [NUM_BITS-1:0] v;
        for (int i = 0; i < NUM_BITS; i++) begin
            v[i] = (idx == IN_BITS'(i));
        end
        return v;
    endfunction

    // Bits 0..code set, everything above clear.
    function automatic logic [NUM_BITS-1:0] thermo(input logic [IN_BITS-1:0] idx);
        logic [NUM_BITS-1:0] v;
        for (int i = 0; i < NUM_BITS; i++) begin
            v[i] = (IN_BITS'(i) <= idx);
        end
        return v;
    endfunction

    // Scan pointer wraps at NUM_BITS, which need not be a power of two.
    function automatic logic [IN_BITS-1:0] ptr_next(input logic [IN_BITS-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign mode_cmd      = mode_e'(mode);
    assign code_in_range = ({1'b0, binary_in} < CODE_LIMIT);
    assign consume       = out_valid_q && out_ready;
    // Using out_ready here lets a new command load in the cycle the old beat leaves.
    assign in_ready      = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept        = in_valid && in_ready;

    assign out_valid   = out_valid_q;
    assign decoder_out = data_q;
    assign out_err     = err_q;
    assign out_last    = last_q;
    assign busy        = (state_q == ST_SCAN);

    // Next-state: load a command beat in IDLE, step the scan in SCAN, else hold or drain.
    always_comb begin
        // NOTE: every target gets a hold default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        err_d       = err_q;
        last_d      = last_q;

        if (state_q == ST_SCAN) begin
            if (consume) begin
                data_d      = onehot(ptr_q);
                err_d       = 1'b0;
                last_d      = (remaining_q == CNT_BITS'(1));
                ptr_d       = ptr_next(ptr_q);
                remaining_d = remaining_q - 1'b1;
                out_valid_d = 1'b1;
                if (remaining_q == CNT_BITS'(1)) begin
                    state_d = ST_IDLE;
                end
            end
        end else if (accept) begin
            out_valid_d = 1'b1;
            data_d      = '0;
            err_d       = 1'b0;
            last_d      = 1'b1;
            if (!enable) begin
                // Disabled commands produce a clean all-zero beat, even for bad codes.
                data_d = '0;
            end else if (!code_in_range || mode_cmd == MODE_RSVD) begin
                err_d = 1'b1;
            end else begin
                case (mode_cmd)
                    MODE_ONEHOT: data_d = onehot(binary_in);
                    MODE_THERMO: data_d = thermo(binary_in);
                    MODE_SCAN: begin
                        data_d = onehot(binary_in);
                        if (count != '0) begin
                            last_d      = 1'b0;
                            ptr_d       = ptr_next(binary_in);
                            remaining_d = count;
                            state_d     = ST_SCAN;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output register; reset discards any in-flight beat or scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the same pre-edge values.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            err_q       <= err_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_decoder_stream.sv
// Self-checking bench for decoder_stream. Two instances (NUM_BITS 16 and 10)
// see identical stimulus; each is compared every cycle against a
// transaction-level model that expands each command into its list of beats.

module tb_decoder_stream;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [3:0]  binary_in;
    logic [1:0]  mode;
    logic [3:0]  count;
    logic        enable;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_err, a_out_last, a_busy;
    logic [15:0] a_decoder_out;
    logic        b_in_ready, b_out_valid, b_out_err, b_out_last, b_busy;
    logic [9:0]  b_decoder_out;

    int n_pass   = 0;
    int n_checks = 0;

    decoder_stream #(.IN_BITS(4), .NUM_BITS(16), .CNT_BITS(4)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .binary_in(binary_in), .mode(mode), .count(count), .enable(enable),
        .out_valid(a_out_valid), .out_ready(out_ready), .decoder_out(a_decoder_out),
        .out_err(a_out_err), .out_last(a_out_last), .busy(a_busy)
    );

    decoder_stream #(.IN_BITS(4), .NUM_BITS(10), .CNT_BITS(4)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .binary_in(binary_in), .mode(mode), .count(count), .enable(enable),
        .out_valid(b_out_valid), .out_ready(out_ready), .decoder_out(b_decoder_out),
        .out_err(b_out_err), .out_last(b_out_last), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          nb [2] = '{16, 10};
    logic        m_valid [2];
    logic [15:0] m_data  [2];
    logic        m_err   [2];
    logic        m_last  [2];
    logic [15:0] pend    [2][16];
    int          m_rd    [2];
    int          m_n     [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic string tg(input int id, input string what);
        return $sformatf("n%0d.%s", nb[id], what);
    endfunction

    function automatic logic o_ready(input int id);
        return (id == 0) ? a_in_ready : b_in_ready;
    endfunction
    function automatic logic o_valid(input int id);
        return (id == 0) ? a_out_valid : b_out_valid;
    endfunction
    function automatic logic [15:0] o_data(input int id);
        return (id == 0) ? a_decoder_out : {6'b0, b_decoder_out};
    endfunction
    function automatic logic o_err(input int id);
        return (id == 0) ? a_out_err : b_out_err;
    endfunction
    function automatic logic o_last(input int id);
        return (id == 0) ? a_out_last : b_out_last;
    endfunction
    function automatic logic o_busy(input int id);
        return (id == 0) ? a_busy : b_busy;
    endfunction

    function automatic logic m_pending(input int id);
        return m_rd[id] < m_n[id];
    endfunction
    function automatic logic m_ready(input int id);
        return !m_pending(id) && (!m_valid[id] || out_ready);
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_valid[id] = 1'b0;
            m_data[id]  = '0;
            m_err[id]   = 1'b0;
            m_last[id]  = 1'b0;
            m_rd[id]    = 0;
            m_n[id]     = 0;
        end
    endtask

    // Advance one instance's model by one clock, using the current inputs.
    task automatic model_step(input int id);
        logic consume;
        logic acc;
        int   code;
        consume = m_valid[id] && out_ready;
        acc     = in_valid && m_ready(id);
        code    = int'(binary_in);
        if (m_pending(id)) begin
            if (consume) begin
                m_data[id] = pend[id][m_rd[id]];
                m_err[id]  = 1'b0;
                m_last[id] = (m_rd[id] == m_n[id] - 1);
                m_rd[id]++;
            end
        end else if (acc) begin
            m_valid[id] = 1'b1;
            m_data[id]  = '0;
            m_err[id]   = 1'b0;
            m_last[id]  = 1'b1;
            m_rd[id]    = 0;
            m_n[id]     = 0;
            if (!enable) begin
                m_data[id] = '0;
            end else if (code >= nb[id] || mode == 2'b11) begin
                m_err[id] = 1'b1;
            end else if (mode == 2'b00) begin
                m_data[id] = 16'(1 << code);
            end else if (mode == 2'b01) begin
                m_data[id] = 16'((1 << (code + 1)) - 1);
            end else begin
                for (int k = 0; k <= int'(count); k++) begin
                    pend[id][k] = 16'(1 << ((code + k) % nb[id]));
                end
                m_data[id] = pend[id][0];
                m_last[id] = (count == 0);
                m_rd[id]   = 1;
                m_n[id]    = int'(count) + 1;
            end
        end else if (consume) begin
            m_valid[id] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int id = 0; id < 2; id++) begin
            check(tg(id, "out_valid"), 32'(o_valid(id)), 32'(m_valid[id]));
            check(tg(id, "busy"), 32'(o_busy(id)), 32'(m_pending(id)));
            if (m_valid[id]) begin
                check(tg(id, "decoder_out"), 32'(o_data(id)), 32'(m_data[id]));
                check(tg(id, "out_err"), 32'(o_err(id)), 32'(m_err[id]));
                check(tg(id, "out_last"), 32'(o_last(id)), 32'(m_last[id]));
            end
        end
    endtask

    // One clock: drive inputs, check in_ready, step model, then check registered outputs.
    task automatic cycle(input logic v, input logic [3:0] c, input logic [1:0] md,
                         input logic [3:0] cn, input logic en, input logic ordy);
        in_valid  = v;
        binary_in = c;
        mode      = md;
        count     = cn;
        enable    = en;
        out_ready = ordy;
        #1;
        for (int id = 0; id < 2; id++) begin
            check(tg(id, "in_ready"), 32'(o_ready(id)), 32'(m_ready(id)));
            model_step(id);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drain();
        repeat (20) cycle(1'b0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        for (int id = 0; id < 2; id++) begin
            check(tg(id, "rst.out_valid"), 32'(o_valid(id)), 32'd0);
            check(tg(id, "rst.busy"), 32'(o_busy(id)), 32'd0);
            check(tg(id, "rst.decoder_out"), 32'(o_data(id)), 32'd0);
            check(tg(id, "rst.out_err"), 32'(o_err(id)), 32'd0);
            check(tg(id, "rst.out_last"), 32'(o_last(id)), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int id = 0; id < 2; id++) begin
            check(tg(id, "rst.in_ready"), 32'(o_ready(id)), 32'd1);
        end
    endtask

    logic [15:0] seen [16];
    int          seen_n;
    int          busy_cycles;
    logic        done;
    logic        ordy;
    logic        held;
    logic [15:0] prev;
    logic [15:0] exp_scan10 [5] = '{16'h100, 16'h200, 16'h001, 16'h002, 16'h004};

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        binary_in = '0;
        mode      = '0;
        count     = '0;
        enable    = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // One-hot code 5, then all 16 codes back-to-back.
        cycle(1'b1, 4'd5, 2'b00, 4'd0, 1'b1, 1'b1);
        check("oh5.data", 32'(a_decoder_out), 32'h0020);
        check("oh5.last", 32'(a_out_last), 32'd1);
        check("oh5.err", 32'(a_out_err), 32'd0);
        for (int c = 0; c < 16; c++) begin
            cycle(1'b1, 4'(c), 2'b00, 4'd0, 1'b1, 1'b1);
            check($sformatf("oh_b2b%0d", c), 32'(a_decoder_out), 32'(1 << c));
        end

        // Thermometer and disabled commands.
        cycle(1'b1, 4'd3, 2'b01, 4'd0, 1'b1, 1'b1);
        check("th3", 32'(a_decoder_out), 32'h000F);
        cycle(1'b1, 4'd15, 2'b01, 4'd0, 1'b1, 1'b1);
        check("th15", 32'(a_decoder_out), 32'hFFFF);
        check("th15.n10err", 32'(b_out_err), 32'd1);
        for (int m = 0; m < 4; m++) begin
            cycle(1'b1, 4'd7, 2'(m), 4'd5, 1'b0, 1'b1);
            check($sformatf("dis%0d.data", m), 32'(a_decoder_out), 32'd0);
            check($sformatf("dis%0d.err", m), 32'(a_out_err), 32'd0);
        end
        drain();

        // Wrapping scan on the NUM_BITS=10 instance: start 8, count 4.
        cycle(1'b1, 4'd8, 2'b10, 4'd4, 1'b1, 1'b1);
        busy_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cycle(1'b0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1);
            check($sformatf("scan10.beat%0d", k), 32'(b_decoder_out), 32'(exp_scan10[k]));
            check($sformatf("scan10.last%0d", k), 32'(b_out_last), 32'(k == 4));
            if (b_busy) busy_cycles++;
        end
        check("scan10.busy_cycles", 32'(busy_cycles), 32'd4);
        drain();

        // Out-of-range code and reserved mode on the NUM_BITS=10 instance.
        cycle(1'b1, 4'd12, 2'b00, 4'd0, 1'b1, 1'b1);
        check("oor.data", 32'(b_decoder_out), 32'd0);
        check("oor.err", 32'(b_out_err), 32'd1);
        check("oor.last", 32'(b_out_last), 32'd1);
        cycle(1'b1, 4'd2, 2'b11, 4'd0, 1'b1, 1'b1);
        check("rsvd.data", 32'(b_decoder_out), 32'd0);
        check("rsvd.err", 32'(b_out_err), 32'd1);
        drain();

        // Scan under back-pressure: out_ready pattern 1,0,0 repeating.
        cycle(1'b1, 4'd0, 2'b10, 4'd3, 1'b1, 1'b1);
        seen_n = 0;
        done   = 1'b0;
        held   = 1'b0;
        prev   = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            ordy = (i % 3 == 0);
            if (held) check("bp.hold", 32'(a_decoder_out), 32'(prev));
            if (a_out_valid && ordy && seen_n < 16) begin
                seen[seen_n] = a_decoder_out;
                seen_n++;
                if (a_out_last) done = 1'b1;
            end
            held = a_out_valid && !ordy;
            prev = a_decoder_out;
            cycle(1'b0, 4'd0, 2'b00, 4'd0, 1'b1, ordy);
        end
        check("bp.beats", 32'(seen_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp.beat%0d", k), 32'(seen[k]), 32'(1 << k));
        end
        drain();

        // Reset on the second beat of an 8-beat scan, then a fresh command.
        cycle(1'b1, 4'd0, 2'b10, 4'd7, 1'b1, 1'b1);
        cycle(1'b0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1);
        check("mid.beat2", 32'(a_decoder_out), 32'h0002);
        do_reset();
        cycle(1'b1, 4'd1, 2'b00, 4'd0, 1'b1, 1'b1);
        check("post.data", 32'(a_decoder_out), 32'h0002);
        check("post.last", 32'(a_out_last), 32'd1);
        cycle(1'b0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1);
        check("post.no_leftover", 32'(a_out_valid), 32'd0);
        check("post.busy", 32'(a_busy), 32'd0);

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
                      4'($urandom), 1'($urandom_range(0, 7) != 0),
                      1'($urandom_range(0, 3) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
